// File: rtl/pov_loader_pkg.sv
// Shared constants for the POV vector loader: Q12.12 word split, frame length, field order.
// Frame length grows by one checksum byte when POV_LOADER_CHECKSUM_EN is defined.
package pov_loader_pkg;

  localparam int unsigned QmBits     = 12;
  localparam int unsigned QnBits     = 12;
  localparam int unsigned DefaultQmn = QmBits + QnBits;
  localparam int unsigned NumFields  = 6;

`ifdef POV_LOADER_CHECKSUM_EN
  localparam int unsigned ChkBits = 8;
`else
  localparam int unsigned ChkBits = 0;
`endif

  localparam int unsigned FRAME_BITS = NumFields * DefaultQmn + ChkBits;

  // Field order on the wire, first field is most significant in the shift register.
  localparam int unsigned IdxPlayerX = 0;
  localparam int unsigned IdxPlayerY = 1;
  localparam int unsigned IdxFacingX = 2;
  localparam int unsigned IdxFacingY = 3;
  localparam int unsigned IdxVplaneX = 4;
  localparam int unsigned IdxVplaneY = 5;

  localparam logic [DefaultQmn-1:0] StartPlayerX = 24'h001800;
  localparam logic [DefaultQmn-1:0] StartPlayerY = 24'h00D800;
  localparam logic [DefaultQmn-1:0] StartFacingX = 24'h000000;
  localparam logic [DefaultQmn-1:0] StartFacingY = 24'hFFF000;
  localparam logic [DefaultQmn-1:0] StartVplaneX = 24'h000800;
  localparam logic [DefaultQmn-1:0] StartVplaneY = 24'h000000;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  function automatic int unsigned frame_bits(input int unsigned qmn);
    return NumFields * qmn + ChkBits;
  endfunction

  // LSB position of a field inside the payload (checksum byte excluded).
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned qmn);
    return (NumFields - 1 - idx) * qmn;
  endfunction

endpackage

// File: rtl/pov_loader_if.sv
// Host-side SPI/tick inputs and pending vector-set outputs of the POV loader.
interface pov_loader_if
  import pov_loader_pkg::*;
#(
  parameter int unsigned QMN = DefaultQmn
) ();

  logic           spi_sck;
  logic           spi_csb;
  logic           spi_mosi;
  logic           tick;
  logic           write_new_position;
  logic [QMN-1:0] new_playerX;
  logic [QMN-1:0] new_playerY;
  logic [QMN-1:0] new_facingX;
  logic [QMN-1:0] new_facingY;
  logic [QMN-1:0] new_vplaneX;
  logic [QMN-1:0] new_vplaneY;
  logic           load_done;
  logic           frame_err;

  modport master (
    output spi_sck, spi_csb, spi_mosi, tick,
    input  write_new_position, new_playerX, new_playerY, new_facingX, new_facingY,
           new_vplaneX, new_vplaneY, load_done, frame_err
  );

  modport slave (
    input  spi_sck, spi_csb, spi_mosi, tick,
    output write_new_position, new_playerX, new_playerY, new_facingX, new_facingY,
           new_vplaneX, new_vplaneY, load_done, frame_err
  );

endinterface

// File: rtl/pov_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags sck/csb edges.
module pov_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck_i,
  input  logic spi_csb_i,
  input  logic spi_mosi_i,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_rise_o,
  output logic csb_fall_o
);

  logic [SYNC_STAGES-1:0] sck_q, csb_q, mosi_q;
  logic                   sck_prev_q, csb_prev_q;
  logic                   sck_s, csb_s;

  assign sck_s = sck_q[SYNC_STAGES-1];
  assign csb_s = csb_q[SYNC_STAGES-1];

  // csb resets low so a low csb at reset release produces no fall edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q      <= '0;
      csb_q      <= '0;
      mosi_q     <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b0;
    end else begin
      sck_q      <= (sck_q << 1) | SYNC_STAGES'(spi_sck_i);
      csb_q      <= (csb_q << 1) | SYNC_STAGES'(spi_csb_i);
      mosi_q     <= (mosi_q << 1) | SYNC_STAGES'(spi_mosi_i);
      sck_prev_q <= sck_s;
      csb_prev_q <= csb_s;
    end
  end

  assign mosi_o     = mosi_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_s & ~sck_prev_q;
  assign sck_fall_o = ~sck_s & sck_prev_q;
  assign csb_rise_o = csb_s & ~csb_prev_q;
  assign csb_fall_o = ~csb_s & csb_prev_q;

endmodule

// File: rtl/pov_loader.sv
// SPI-fed loader for the renderer's position/facing/plane vectors, handed over at frame tick.
// Define POV_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module pov_loader
  import pov_loader_pkg::*;
#(
  parameter int unsigned QMN         = DefaultQmn,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  pov_loader_if.slave bus
);

  localparam int unsigned FrameBits   = frame_bits(QMN);
  localparam int unsigned PayloadBits = NumFields * QMN;
  localparam int unsigned CntW        = $clog2(FrameBits + 1);

  logic mosi, sck_rise, sck_fall, csb_rise, csb_fall;

  pov_spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .spi_sck_i  (bus.spi_sck),
    .spi_csb_i  (bus.spi_csb),
    .spi_mosi_i (bus.spi_mosi),
    .mosi_o     (mosi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csb_rise_o (csb_rise),
    .csb_fall_o (csb_fall)
  );

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FrameBits-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic [PayloadBits-1:0] vec_q, vec_d;
  logic                   pending_q, pending_d;
  logic                   load_done_q, load_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   commit, discard, chk_ok;

`ifdef POV_LOADER_CHECKSUM_EN
  logic [7:0] chk;

  always_comb begin
    chk = 8'h00;
    for (int i = 0; i < int'(PayloadBits / 8); i++) begin
      chk = chk ^ shift_q[ChkBits + 8 * i +: 8];
    end
  end

  assign chk_ok = (chk == shift_q[7:0]);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    armed_d = armed_q;
    commit  = 1'b0;
    discard = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (csb_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          armed_d = 1'b1;
        end
      end
      StShift: begin
        if (csb_rise) begin
          state_d = StIdle;
          if (cnt_q == CntW'(FrameBits) && chk_ok) commit = 1'b1;
          else discard = 1'b1;
        end else if (sck_rise && armed_q) begin
          // One bit per sck period; armed is re-set by the following fall.
          shift_d = {shift_q[FrameBits-2:0], mosi};
          armed_d = 1'b0;
          if (cnt_q != {CntW{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (sck_fall) begin
          armed_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_d       = commit ? shift_q[FrameBits-1 -: PayloadBits] : vec_q;
    // A commit on the tick edge keeps the new set pending while the old one is consumed.
    pending_d   = commit | (pending_q & ~bus.tick);
    load_done_d = pending_q & bus.tick;
    frame_err_d = discard;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      vec_q       <= '0;
      pending_q   <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      vec_q       <= vec_d;
      pending_q   <= pending_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.write_new_position = pending_q;
  assign bus.load_done          = load_done_q;
  assign bus.frame_err          = frame_err_q;
  assign bus.new_playerX        = vec_q[field_lsb(IdxPlayerX, QMN) +: QMN];
  assign bus.new_playerY        = vec_q[field_lsb(IdxPlayerY, QMN) +: QMN];
  assign bus.new_facingX        = vec_q[field_lsb(IdxFacingX, QMN) +: QMN];
  assign bus.new_facingY        = vec_q[field_lsb(IdxFacingY, QMN) +: QMN];
  assign bus.new_vplaneX        = vec_q[field_lsb(IdxVplaneX, QMN) +: QMN];
  assign bus.new_vplaneY        = vec_q[field_lsb(IdxVplaneY, QMN) +: QMN];

endmodule

// File: tb/tb_pov_loader.sv
// Directed bench for pov_loader: frame commit, short frame, overwrite, tick-aligned commit,
// mid-frame reset and (with POV_LOADER_CHECKSUM_EN) checksum rejection.
module tb_pov_loader;

  localparam int unsigned Qmn = 24;
`ifdef POV_LOADER_CHECKSUM_EN
  localparam int unsigned Fb = 152;
`else
  localparam int unsigned Fb = 144;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pov_loader_if #(.QMN(Qmn)) bus ();

  pov_loader #(
    .QMN        (Qmn),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int ld_cnt = 0;
  int fe_cnt = 0;

  // Registered pulses are stable at the rising edge, so count them there.
  always @(posedge clk) begin
    if (bus.load_done) ld_cnt++;
    if (bus.frame_err) fe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [Fb-1:0] make_frame(input logic [23:0] px, input logic [23:0] py,
                                               input logic [23:0] fx, input logic [23:0] fy,
                                               input logic [23:0] vx, input logic [23:0] vy);
    logic [143:0] p;
    p = {px, py, fx, fy, vx, vy};
`ifdef POV_LOADER_CHECKSUM_EN
    begin
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < 18; i++) c = c ^ p[8 * i +: 8];
      return {p, c};
    end
`else
    return p;
`endif
  endfunction

  // Sends the first nbits of data MSB first; sck period is 6 clk.
  task automatic send_frame(input logic [Fb-1:0] data, input int nbits, input int reset_at,
                            input bit tick_at_commit);
    @(negedge clk);
    bus.spi_csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
      end
      bus.spi_mosi = data[Fb-1-i];
      repeat (3) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.spi_csb = 1'b1;
    if (tick_at_commit) begin
      // Commit lands on the third rising edge after the raw csb rise.
      repeat (2) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_tick(input logic exp_pending);
    @(negedge clk);
    bus.tick = 1'b1;
    check_eq("wnp_on_tick", bus.write_new_position, exp_pending);
    @(negedge clk);
    bus.tick = 1'b0;
    check_eq("wnp_after_tick", bus.write_new_position, 1'b0);
    check_eq("load_done_pulse", bus.load_done, exp_pending);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [Fb-1:0] f;
    int base_ld, base_fe;

    bus.spi_sck  = 1'b0;
    bus.spi_csb  = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tick     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wnp", bus.write_new_position, 1'b0);
    check_eq("rst_load_done", bus.load_done, 1'b0);
    check_eq("rst_frame_err", bus.frame_err, 1'b0);
    check_eq("rst_playerX", bus.new_playerX, 24'h0);
    check_eq("rst_facingY", bus.new_facingY, 24'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame then tick
    base_ld = ld_cnt;
    base_fe = fe_cnt;
    f = make_frame(24'h001800, 24'h00D800, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000);
    send_frame(f, Fb, -1, 1'b0);
    check_eq("t1_pending", bus.write_new_position, 1'b1);
    do_tick(1'b1);
    check_eq("t1_playerX", bus.new_playerX, 24'h001800);
    check_eq("t1_playerY", bus.new_playerY, 24'h00D800);
    check_eq("t1_facingX", bus.new_facingX, 24'h000000);
    check_eq("t1_facingY", bus.new_facingY, 24'hFFF000);
    check_eq("t1_vplaneX", bus.new_vplaneX, 24'h000800);
    check_eq("t1_vplaneY", bus.new_vplaneY, 24'h000000);
    check_eq("t1_load_done_count", 64'(ld_cnt - base_ld), 64'd1);
    check_eq("t1_frame_err_count", 64'(fe_cnt - base_fe), 64'd0);

    // Short frame is discarded
    base_fe = fe_cnt;
    f = make_frame(24'h123456, 24'h654321, 24'h111111, 24'h222222, 24'h333333, 24'h444444);
    send_frame(f, Fb - 1, -1, 1'b0);
    check_eq("t2_frame_err_count", 64'(fe_cnt - base_fe), 64'd1);
    check_eq("t2_pending", bus.write_new_position, 1'b0);
    check_eq("t2_playerX", bus.new_playerX, 24'h001800);
    check_eq("t2_facingY", bus.new_facingY, 24'hFFF000);

    // Two frames before tick: latest wins
    base_ld = ld_cnt;
    base_fe = fe_cnt;
    f = make_frame(24'h001800, 24'h00D800, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000);
    send_frame(f, Fb, -1, 1'b0);
    f = make_frame(24'h002800, 24'h00D800, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000);
    send_frame(f, Fb, -1, 1'b0);
    check_eq("t3_pending", bus.write_new_position, 1'b1);
    check_eq("t3_playerX", bus.new_playerX, 24'h002800);
    do_tick(1'b1);
    check_eq("t3_load_done_count", 64'(ld_cnt - base_ld), 64'd1);
    check_eq("t3_frame_err_count", 64'(fe_cnt - base_fe), 64'd0);

    // Commit on the same edge as tick
    f = make_frame(24'h003000, 24'h000100, 24'h000200, 24'h000300, 24'h000400, 24'h000500);
    send_frame(f, Fb, -1, 1'b0);
    base_ld = ld_cnt;
    f = make_frame(24'h004000, 24'h000A00, 24'h000B00, 24'h000C00, 24'h000D00, 24'h000E00);
    send_frame(f, Fb, -1, 1'b1);
    check_eq("t4_load_done_count", 64'(ld_cnt - base_ld), 64'd1);
    check_eq("t4_pending", bus.write_new_position, 1'b1);
    check_eq("t4_playerX", bus.new_playerX, 24'h004000);
    check_eq("t4_vplaneY", bus.new_vplaneY, 24'h000E00);
    do_tick(1'b1);

    // Reset at bit 70, then a clean frame
    base_fe = fe_cnt;
    f = make_frame(24'h005000, 24'h005100, 24'h005200, 24'h005300, 24'h005400, 24'h005500);
    send_frame(f, Fb, 70, 1'b0);
    check_eq("t5_pending_after_abort", bus.write_new_position, 1'b0);
    check_eq("t5_playerX_cleared", bus.new_playerX, 24'h0);
    check_eq("t5_frame_err_abort", 64'(fe_cnt - base_fe), 64'd0);
    f = make_frame(24'h006000, 24'h006100, 24'h006200, 24'h006300, 24'h006400, 24'h006500);
    send_frame(f, Fb, -1, 1'b0);
    check_eq("t5_pending", bus.write_new_position, 1'b1);
    check_eq("t5_playerX", bus.new_playerX, 24'h006000);
    check_eq("t5_vplaneX", bus.new_vplaneX, 24'h006400);
    check_eq("t5_frame_err_count", 64'(fe_cnt - base_fe), 64'd0);
    do_tick(1'b1);

`ifdef POV_LOADER_CHECKSUM_EN
    // Corrupt checksum rejected, correct one accepted
    base_fe = fe_cnt;
    f = make_frame(24'h007000, 24'h007100, 24'h007200, 24'h007300, 24'h007400, 24'h007500);
    f[7:0] = f[7:0] ^ 8'h5A;
    send_frame(f, Fb, -1, 1'b0);
    check_eq("t6_bad_frame_err", 64'(fe_cnt - base_fe), 64'd1);
    check_eq("t6_bad_pending", bus.write_new_position, 1'b0);
    check_eq("t6_bad_playerX", bus.new_playerX, 24'h006000);
    f = make_frame(24'h007000, 24'h007100, 24'h007200, 24'h007300, 24'h007400, 24'h007500);
    send_frame(f, Fb, -1, 1'b0);
    check_eq("t6_good_frame_err", 64'(fe_cnt - base_fe), 64'd1);
    check_eq("t6_good_pending", bus.write_new_position, 1'b1);
    check_eq("t6_good_playerX", bus.new_playerX, 24'h007000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pov_loader.md
POV_LOADER -- requirements
Module: pov_loader

Interface
REQ-001 Parameter QMN, default 24, fixed-point word width (Q12.12) of each vector component.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth for the SPI inputs.
REQ-003 clk  input  1  system/pixel clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 spi_sck  input  1  host SPI clock, asynchronous to clk, mode 0, at most clk/4.
REQ-006 spi_csb  input  1  host chip select, active-low; frames one transaction.
REQ-007 spi_mosi  input  1  host serial data, MSB first.
REQ-008 tick  input  1  one-clk pulse at frame start (h==0, v==0) from the renderer.
REQ-009 write_new_position  output  1  high while a validated vector set is pending.
REQ-010 new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY  output  QMN each  pending vector set.
REQ-011 load_done  output  1  one-clk pulse when the pending set is consumed at tick.
REQ-012 frame_err  output  1  one-clk pulse when a transaction is discarded.

Function
REQ-013 spi_sck, spi_csb and spi_mosi SHALL pass through SYNC_STAGES flops; sck rise/fall and csb fall/rise SHALL be detected in the clk domain.
REQ-014 FSM states: IDLE (csb high), SHIFT (csb low); csb fall IDLE->SHIFT clears the bit counter; csb rise SHIFT->IDLE triggers evaluation.
REQ-015 In SHIFT, each synchronised sck rise SHALL shift mosi into a 6*QMN shift register and increment the bit counter, saturating at its maximum.
REQ-016 Field order SHALL be playerX, playerY, facingX, facingY, vplaneX, vplaneY; each field MSB first.
REQ-017 On csb rise with exactly FRAME_BITS counted, the shift register SHALL be copied into the new_* registers on the next clk and pending set.
REQ-018 On csb rise with any other count, data SHALL be discarded, new_* unchanged, frame_err pulsed one clk.
REQ-019 write_new_position SHALL equal the registered pending flag, so it is high during the tick cycle that consumes it.
REQ-020 On tick with pending high, pending SHALL clear on that edge and load_done pulse the following cycle.
REQ-021 A commit while pending is already set SHALL overwrite new_*; latest set wins, no error.
REQ-022 Commit and tick on the same edge: old values are consumed, new values load, pending stays high, load_done pulses.
REQ-023 new_* SHALL remain stable between commits; sck edges outside SHIFT SHALL be ignored.
REQ-024 Latency: commit within SYNC_STAGES+2 clks after raw csb rise.

Reset
REQ-025 Asserting reset SHALL force IDLE, counter 0, shift register 0, pending 0, all outputs 0, including mid-transaction.
REQ-026 If csb is low when reset releases, the module SHALL wait for csb high then low before shifting.

Configuration
REQ-027 With POV_LOADER_CHECKSUM_EN defined, FRAME_BITS = 6*QMN+8; the trailing byte SHALL equal the XOR of all preceding bytes, else the frame is discarded with frame_err.
REQ-028 Without POV_LOADER_CHECKSUM_EN, FRAME_BITS = 6*QMN and no checksum logic SHALL exist.

Structure
REQ-029 Shared package/header: QMN, Qm/Qn split, FRAME_BITS, field-order index constants, start-vector constants.
REQ-030 One sub-module, pov_spi_sync: synchroniser plus sck/csb edge detectors.

Verification
REQ-031 144-bit frame playerX=0x001800, playerY=0x00D800, facingX=0, facingY=0xFFF000, vplaneX=0x000800, vplaneY=0, then tick -> write_new_position high on tick cycle, new_* exact, load_done pulses once.
REQ-032 143-bit frame -> frame_err one pulse, pending 0, new_* unchanged.
REQ-033 Two valid frames before tick (playerX 0x001800 then 0x002800) -> single write_new_position, new_playerX=0x002800.
REQ-034 Commit aligned to tick edge -> load_done pulses, pending remains 1 with new values.
REQ-035 reset asserted at bit 70, released, then full frame -> only second frame committed, no frame_err from the first.
REQ-036 With POV_LOADER_CHECKSUM_EN, corrupt checksum byte -> frame_err, no commit; correct checksum -> commit.
